af_sweep_ctrl: RTL and testbench
================================

# af_sweep_ctrl

Autofocus sweep controller for the D8M camera path. It steps the VCM lens position from STEP_MIN to STEP_MAX in STEP_INC increments and waits SETTLE_FRAMES frames at each position. It then captures one sharpness score per position, tracks the peak, and finally drives the lens to the best position and holds it. It sits between the frame-statistics block (sharpness, frame_end) and the I2C VCM writer (req/ack).

## Interface
- STEP_MIN, 0: first lens position.
- STEP_MAX, 1023: last lens position (10-bit).
- STEP_INC, 16: position increment; must be ≥1.
- SETTLE_FRAMES, 2: frame_end pulses to wait after each move before measuring; must be ≥1.
- SW, 32: sharpness width.

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  reset RESET_n, asynchronous, active-low; clock CLK
- start  in  1  1-cycle pulse, begins a sweep; ignored while busy=1
- abort  in  1  1-cycle pulse, cancels the sweep
- frame_end  in  1  1-cycle pulse per frame
- sharp  in  SW  sharpness of the last frame
- sharp_vld  in  1  1-cycle pulse qualifying sharp
- vcm_step  out  10  lens position presented to the VCM writer
- vcm_req  out  1  write request; held until vcm_ack
- vcm_ack  in  1  1-cycle pulse, write complete
- busy  out  1  sweep in progress
- done  out  1  1-cycle pulse when the lens is parked at the best position
- best_step  out  10  position of the peak
- best_sharp  out  SW  peak score

## Operation
- States: IDLE, MOVE, SETTLE, MEASURE, NEXT, SEEK, HOLD.
- **IDLE**
  - On start: cur ← STEP_MIN, best_sharp ← 0, best_step ← STEP_MIN, go to MOVE.
- **MOVE**
  - vcm_req=1 with vcm_step=cur.
  - On vcm_ack: clear the frame counter and go to SETTLE.
- **SETTLE**
  - Count frame_end pulses.
  - On the SETTLE_FRAMES-th pulse, go to MEASURE.
- **MEASURE**
  - On sharp_vld: if sharp > best_sharp (strict), update best_sharp and best_step ← cur.
  - Go to NEXT.
  - Ties keep the earlier (lower) position.
- **NEXT**
  - If cur == STEP_MAX, go to SEEK.
  - Otherwise cur ← min(cur+STEP_INC, STEP_MAX), go to MOVE.
  - The sum is computed 11 bits wide, so there is no 10-bit wrap.
- **SEEK**
  - vcm_req=1 with vcm_step=best_step.
  - On vcm_ack, go to HOLD.
- **HOLD**
  - done pulses on entry (one cycle); busy=0.
  - vcm_step holds best_step.
  - start starts a new sweep exactly as from IDLE.
- **Filtering rules**
  - sharp_vld outside MEASURE is ignored.
  - frame_end outside SETTLE is ignored.
  - vcm_ack outside MOVE/SEEK is ignored.
- **abort**
  - In SETTLE, MEASURE or NEXT: go to IDLE next cycle.
  - In MOVE or SEEK: latch a pending abort. vcm_req stays high until vcm_ack, then go to IDLE; the req/ack handshake is never broken.
  - abort in IDLE or HOLD: no effect.
  - Simultaneous start and abort in IDLE/HOLD: start wins.
- busy=1 in every state except IDLE and HOLD.

## Timing
- **Reset values:** state IDLE, vcm_step=0, vcm_req=0, busy=0, done=0, best_step=0, best_sharp=0. Pending abort and frame counter are cleared.
- All outputs are registered.
- **start → request:** start sampled at edge t gives busy=1, vcm_req=1, vcm_step=STEP_MIN after edge t+1.
- **Request handshake:**
  - vcm_ack at edge a gives vcm_req=0 after edge a+1.
  - vcm_step is stable whenever vcm_req=1.
- **SETTLE → MEASURE:** the last frame_end at edge f makes the state MEASURE after f+1. A sharp_vld at edge f+1 is accepted.
- **Per-position overhead:** sharp_vld at edge m gives state NEXT after m+1 and vcm_req=1 after m+2. The overhead is 2 cycles plus the ack latency.
- **done:** ack for SEEK at edge s gives done=1 for the single cycle after s+1.

## Structure
- Package af_pkg holds:
  - the state enum;
  - the 10-bit step type;
  - the constant STEP_W=10.
- Sub-module af_peak_track holds best_sharp/best_step. Its inputs are clear, vld, sharp and cur; it does the strict-greater compare and update.
- The FSM, frame counter and step arithmetic stay in the top.

## Test plan
- **Basic sweep** (STEP_INC=256, SETTLE_FRAMES=2, ack 3 cycles after req)
  - Positions must be 0, 256, 512, 768, 1023 (clamped); feed sharp 10, 50, 50, 20, 5.
  - Required: best_step=256, best_sharp=50, SEEK writes 256, one done pulse, then vcm_step=256.
- **Settling count:** give 3 frame_end pulses per position. sharp_vld after the 1st pulse must be ignored; only the value after the 2nd pulse is scored.
- **Abort in MOVE:** pulse abort while vcm_req=1. vcm_req must hold until ack, then state IDLE, busy=0, no done.
- **Abort in SETTLE:** IDLE on the next cycle. A later vcm_ack/sharp_vld causes no change.
- **start while busy:** ignored. Re-start from HOLD: best_sharp is reset, and a fresh sweep with all-zero sharpness yields best_step=STEP_MIN.
- **Reset mid-SEEK:** asserting RESET_n low gives all outputs their reset values immediately (asynchronously), and vcm_req=0.

Source files
------------

// File: rtl/af_sweep_ctrl_pkg.sv
// Shared types for the autofocus sweep controller: lens step type, FSM states
// and the clamped step-advance helper.
package af_pkg;

  localparam int STEP_W = 10;

  typedef logic [STEP_W-1:0] step_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE    = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    NEXT    = 3'd4,
    SEEK    = 3'd5,
    HOLD    = 3'd6
  } af_state_e;

  // One bit wider than a step so the sum cannot wrap before the clamp.
  function automatic step_t step_advance(input step_t cur,
                                         input logic [STEP_W:0] inc,
                                         input step_t max_step);
    logic [STEP_W:0] sum;
    sum = {1'b0, cur} + inc;
    if (sum > {1'b0, max_step}) return max_step;
    return sum[STEP_W-1:0];
  endfunction

endpackage

// File: rtl/af_sweep_ctrl_peak_track.sv
// Peak tracker: holds the highest sharpness seen this sweep and the lens
// position it was measured at. Ties keep the earlier position.
module af_peak_track
  import af_pkg::*;
#(
  parameter int STEP_MIN = 0,
  parameter int SW       = 32
) (
  input  logic          CLK,
  input  logic          RESET_n,
  input  logic          clear,
  input  logic          vld,
  input  logic [SW-1:0] sharp,
  input  step_t         cur,
  output step_t         best_step,
  output logic [SW-1:0] best_sharp
);

  step_t         best_step_q, best_step_d;
  logic [SW-1:0] best_sharp_q, best_sharp_d;

  always_comb begin
    best_step_d  = best_step_q;
    best_sharp_d = best_sharp_q;
    if (clear) begin
      best_step_d  = STEP_W'(STEP_MIN);
      best_sharp_d = '0;
    end else if (vld && (sharp > best_sharp_q)) begin
      best_step_d  = cur;
      best_sharp_d = sharp;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      best_step_q  <= '0;
      best_sharp_q <= '0;
    end else begin
      best_step_q  <= best_step_d;
      best_sharp_q <= best_sharp_d;
    end
  end

  assign best_step  = best_step_q;
  assign best_sharp = best_sharp_q;

endmodule

// File: rtl/af_sweep_ctrl.sv
// Autofocus sweep controller: steps the VCM across the lens range, scores each
// position after settling, then parks the lens at the sharpest position.
module af_sweep_ctrl
  import af_pkg::*;
#(
  parameter int STEP_MIN      = 0,
  parameter int STEP_MAX      = 1023,
  parameter int STEP_INC      = 16,
  parameter int SETTLE_FRAMES = 2,
  parameter int SW            = 32
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              start,
  input  logic              abort,
  input  logic              frame_end,
  input  logic [SW-1:0]     sharp,
  input  logic              sharp_vld,
  output logic [STEP_W-1:0] vcm_step,
  output logic              vcm_req,
  input  logic              vcm_ack,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] best_step,
  output logic [SW-1:0]     best_sharp
);

  localparam int    FCW      = $clog2(SETTLE_FRAMES + 1);
  localparam step_t MIN_S    = STEP_W'(STEP_MIN);
  localparam step_t MAX_S    = STEP_W'(STEP_MAX);
  localparam logic [STEP_W:0] INC_S = (STEP_W+1)'(STEP_INC);
  localparam logic [FCW-1:0]  LAST_FRAME = FCW'(SETTLE_FRAMES - 1);

  af_state_e      state_q;
  logic [FCW-1:0] fcnt_q;
  logic           abort_pend_q;
  logic           hold_q;
  step_t          vcm_step_q;
  logic           vcm_req_q;
  logic           busy_q;
  logic           done_q;
  step_t          cur_q, cur_d;
  step_t          pk_best_step;
  logic [SW-1:0]  pk_best_sharp;
  logic           start_acc;
  logic           score_vld;

  assign start_acc = start && ((state_q == IDLE) || (state_q == HOLD));
  assign score_vld = sharp_vld && !abort && (state_q == MEASURE);

  af_peak_track #(
    .STEP_MIN (STEP_MIN),
    .SW       (SW)
  ) u_peak (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .clear      (start_acc),
    .vld        (score_vld),
    .sharp      (sharp),
    .cur        (cur_q),
    .best_step  (pk_best_step),
    .best_sharp (pk_best_sharp)
  );

  always_comb begin
    cur_d = cur_q;
    if (start_acc)
      cur_d = MIN_S;
    else if ((state_q == NEXT) && !abort && (cur_q != MAX_S))
      cur_d = step_advance(cur_q, INC_S, MAX_S);
  end

  // cur is always loaded on an accepted start before anything reads it.
  always_ff @(posedge CLK) begin
    cur_q <= cur_d;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= IDLE;
      fcnt_q       <= '0;
      abort_pend_q <= 1'b0;
      hold_q       <= 1'b0;
      vcm_step_q   <= '0;
      vcm_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // Outputs follow the current state one cycle later.
      vcm_req_q <= (state_q == MOVE) || (state_q == SEEK);
      busy_q    <= (state_q != IDLE) && (state_q != HOLD);
      hold_q    <= (state_q == HOLD);
      done_q    <= (state_q == HOLD) && !hold_q;
      if (state_q == MOVE)
        vcm_step_q <= cur_q;
      else if ((state_q == SEEK) || (state_q == HOLD))
        vcm_step_q <= pk_best_step;

      unique case (state_q)
        IDLE, HOLD: begin
          if (start) begin
            state_q      <= MOVE;
            abort_pend_q <= 1'b0;
          end
        end
        MOVE, SEEK: begin
          // Abort never breaks a handshake in flight; it is honoured at ack.
          if (abort) abort_pend_q <= 1'b1;
          if (vcm_ack) begin
            abort_pend_q <= 1'b0;
            fcnt_q       <= '0;
            if (abort || abort_pend_q)
              state_q <= IDLE;
            else
              state_q <= (state_q == MOVE) ? SETTLE : HOLD;
          end
        end
        SETTLE: begin
          if (abort)
            state_q <= IDLE;
          else if (frame_end) begin
            if (fcnt_q == LAST_FRAME)
              state_q <= MEASURE;
            else
              fcnt_q <= fcnt_q + 1'b1;
          end
        end
        MEASURE: begin
          if (abort)
            state_q <= IDLE;
          else if (sharp_vld)
            state_q <= NEXT;
        end
        NEXT: begin
          if (abort)
            state_q <= IDLE;
          else if (cur_q == MAX_S)
            state_q <= SEEK;
          else
            state_q <= MOVE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vcm_step   = vcm_step_q;
  assign vcm_req    = vcm_req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_step  = pk_best_step;
  assign best_sharp = pk_best_sharp;

endmodule

// File: tb/tb_af_sweep_ctrl.sv
// Directed and randomized checks of af_sweep_ctrl against a list-based model
// of the sweep positions and the first-strict-maximum rule.
module tb_af_sweep_ctrl;

  localparam int P_MIN = 0;
  localparam int P_MAX = 1023;
  localparam int P_INC = 256;
  localparam int P_SET = 2;
  localparam int SW    = 32;

  logic          CLK = 1'b0;
  logic          RESET_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          frame_end = 1'b0;
  logic [SW-1:0] sharp = '0;
  logic          sharp_vld = 1'b0;
  logic          vcm_ack = 1'b0;
  logic [9:0]    vcm_step;
  logic          vcm_req;
  logic          busy;
  logic          done;
  logic [9:0]    best_step;
  logic [SW-1:0] best_sharp;

  int          checks = 0;
  int          errors = 0;
  int          pos_q[$];
  logic [31:0] tab[5];
  logic [31:0] exp_best_v;
  int          exp_best_p;

  always #5 CLK = ~CLK;

  af_sweep_ctrl #(
    .STEP_MIN      (P_MIN),
    .STEP_MAX      (P_MAX),
    .STEP_INC      (P_INC),
    .SETTLE_FRAMES (P_SET),
    .SW            (SW)
  ) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .start      (start),
    .abort      (abort),
    .frame_end  (frame_end),
    .sharp      (sharp),
    .sharp_vld  (sharp_vld),
    .vcm_step   (vcm_step),
    .vcm_req    (vcm_req),
    .vcm_ack    (vcm_ack),
    .busy       (busy),
    .done       (done),
    .best_step  (best_step),
    .best_sharp (best_sharp)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic val, input string tag);
    int n = 0;
    while (vcm_req !== val && n < 100) begin
      tick;
      n++;
    end
    check(tag, {31'd0, vcm_req}, {31'd0, val});
  endtask

  task automatic build_positions;
    int p;
    pos_q.delete();
    p = P_MIN;
    forever begin
      pos_q.push_back(p);
      if (p == P_MAX) break;
      p = p + P_INC;
      if (p > P_MAX) p = P_MAX;
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic run_sweep(input bit ack_seek, input bit poke_start);
    build_positions();
    exp_best_v = 0;
    exp_best_p = P_MIN;
    pulse_start();
    check("start_lat_busy", {31'd0, busy}, 0);
    tick;
    check("start_busy", {31'd0, busy}, 1);
    check("start_req", {31'd0, vcm_req}, 1);
    foreach (pos_q[i]) begin
      wait_req(1'b1, "move_req");
      check("move_step", {22'd0, vcm_step}, pos_q[i]);
      repeat (2) tick;
      if (poke_start && i == 1) pulse_start();
      check("move_req_hold", {31'd0, vcm_req}, 1);
      check("move_step_stable", {22'd0, vcm_step}, pos_q[i]);
      vcm_ack = 1'b1;
      tick;
      vcm_ack = 1'b0;
      check("ack_lat", {31'd0, vcm_req}, 1);
      tick;
      check("ack_drop", {31'd0, vcm_req}, 0);
      frame_end = 1'b1;
      tick;
      frame_end = 1'b0;
      sharp = 32'hFFFF_FFFF;
      sharp_vld = 1'b1;
      tick;
      sharp_vld = 1'b0;
      tick;
      frame_end = 1'b1;
      tick;
      frame_end = 1'b0;
      sharp = tab[i];
      sharp_vld = 1'b1;
      tick;
      sharp_vld = 1'b0;
      frame_end = 1'b1;
      tick;
      frame_end = 1'b0;
      if (tab[i] > exp_best_v) begin
        exp_best_v = tab[i];
        exp_best_p = pos_q[i];
      end
    end
    wait_req(1'b1, "seek_req");
    check("seek_step", {22'd0, vcm_step}, exp_best_p);
    check("best_step", {22'd0, best_step}, exp_best_p);
    check("best_sharp", best_sharp, exp_best_v);
    check("seek_busy", {31'd0, busy}, 1);
    if (ack_seek) begin
      tick;
      vcm_ack = 1'b1;
      tick;
      vcm_ack = 1'b0;
      check("done_early", {31'd0, done}, 0);
      tick;
      check("done_pulse", {31'd0, done}, 1);
      tick;
      check("done_single", {31'd0, done}, 0);
      check("hold_busy", {31'd0, busy}, 0);
      check("hold_req", {31'd0, vcm_req}, 0);
      check("hold_step", {22'd0, vcm_step}, exp_best_p);
      repeat (3) tick;
      check("hold_done_quiet", {31'd0, done}, 0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_step"}, {22'd0, vcm_step}, 0);
    check({tag, "_req"}, {31'd0, vcm_req}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_bstep"}, {22'd0, best_step}, 0);
    check({tag, "_bsharp"}, best_sharp, 0);
  endtask

  initial begin
    repeat (3) tick;
    check_reset_vals("rst");
    RESET_n = 1'b1;
    tick;

    // Basic sweep with a tie at 256/512; a start while busy is ignored.
    tab[0] = 10; tab[1] = 50; tab[2] = 50; tab[3] = 20; tab[4] = 5;
    run_sweep(1'b1, 1'b1);
    check("basic_best_step", {22'd0, best_step}, 256);
    check("basic_best_sharp", best_sharp, 50);

    // Random sweeps restarted from HOLD; small range makes ties frequent.
    for (int r = 0; r < 3; r++) begin
      foreach (tab[i]) tab[i] = $urandom_range(0, 7);
      run_sweep(1'b1, 1'b0);
    end

    // All-zero scores after a restart: best must fall back to STEP_MIN.
    foreach (tab[i]) tab[i] = 0;
    run_sweep(1'b1, 1'b0);
    check("zero_best_step", {22'd0, best_step}, P_MIN);
    check("zero_best_sharp", best_sharp, 0);

    // Abort in MOVE: request holds until ack, then idle without done.
    pulse_start();
    tick;
    check("abm_req", {31'd0, vcm_req}, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    repeat (3) tick;
    check("abm_req_hold", {31'd0, vcm_req}, 1);
    check("abm_step_hold", {22'd0, vcm_step}, P_MIN);
    vcm_ack = 1'b1;
    tick;
    vcm_ack = 1'b0;
    tick;
    check("abm_req_drop", {31'd0, vcm_req}, 0);
    check("abm_busy", {31'd0, busy}, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("abm_no_done", {31'd0, done}, 0);
    end
    check("abm_idle", {31'd0, busy}, 0);

    // Abort in SETTLE: idle next cycle; stray ack/frame/sharp do nothing.
    pulse_start();
    tick;
    vcm_ack = 1'b1;
    tick;
    vcm_ack = 1'b0;
    tick;
    check("abs_req_drop", {31'd0, vcm_req}, 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
    check("abs_busy", {31'd0, busy}, 0);
    sharp = 999;
    sharp_vld = 1'b1;
    frame_end = 1'b1;
    vcm_ack = 1'b1;
    tick;
    sharp_vld = 1'b0;
    frame_end = 1'b0;
    vcm_ack = 1'b0;
    repeat (3) tick;
    check("abs_busy_after", {31'd0, busy}, 0);
    check("abs_req_after", {31'd0, vcm_req}, 0);
    check("abs_bsharp", best_sharp, 0);
    check("abs_bstep", {22'd0, best_step}, P_MIN);

    // Reset asserted while the SEEK request is outstanding.
    foreach (tab[i]) tab[i] = $urandom_range(1, 1000);
    run_sweep(1'b0, 1'b0);
    #3;
    RESET_n = 1'b0;
    #1;
    check_reset_vals("rst_seek");
    tick;
    check("rst_seek_req_held", {31'd0, vcm_req}, 0);
    RESET_n = 1'b1;
    repeat (2) tick;
    check_reset_vals("rst_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
